// File: rtl/debug_ctrl_pkg.sv
// Shared types and constants for the debug controller slice.
package debug_ctrl_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
    localparam int unsigned ADDR_W              = 32;
    localparam int unsigned CNT_W               = 32;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_STEP  = 2'd2,
        ST_BREAK = 2'd3
    } dbg_state_t;

endpackage

// File: rtl/debug_step_debounce.sv
// Step button conditioning: 2-flop synchronizer, level debounce and rising-edge pulse.
module debug_step_debounce
    import debug_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic debug_step,
    output logic step_pulse,
    output logic stable
);

    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            sync1;
    logic            sync2;
    logic            stable_d;
    logic [DB_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= debug_step;
            sync2 <= sync1;
        end
    end

    // Any sample matching the current stable level restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (sync2 == stable) begin
            cnt <= '0;
        end else if (cnt == DB_LAST) begin
            cnt    <= '0;
            stable <= sync2;
        end else begin
            cnt <= cnt + DB_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_d   <= 1'b0;
            step_pulse <= 1'b0;
        end else begin
            stable_d   <= stable;
            step_pulse <= stable & ~stable_d;
        end
    end

endmodule

// File: rtl/debug_ctrl.sv
// CPU run/halt/single-step/breakpoint controller with interrupt holding and cycle counting.
module debug_ctrl
    import debug_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              debug_en,
    input  logic              debug_step,
    input  logic              bp_en,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic [ADDR_W-1:0] pc,
    input  logic              interrupter,
    output logic              cpu_en,
    output logic              irq_out,
    output logic              halted,
    output logic              bp_hit,
    output logic [CNT_W-1:0]  cycle_cnt
);

    dbg_state_t state;
    dbg_state_t state_nxt;
    logic       active;
    logic       irq_pending;
    logic       step_pulse;
    logic       step_stable;
    logic       step_go;

    debug_step_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step (
        .clk       (clk),
        .rst       (rst),
        .debug_step(debug_step),
        .step_pulse(step_pulse),
        .stable    (step_stable)
    );

    // Accept the pulse only while the debounced level is still high.
    assign step_go = step_pulse & step_stable;

    // Low while in reset so the CPU stays stopped until the first edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= 1'b0;
        end else begin
            active <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_RUN: begin
                if (debug_en) begin
                    state_nxt = ST_HALT;
                end else if (bp_en && (pc == bp_addr)) begin
                    state_nxt = ST_BREAK;
                end
            end
            ST_HALT: begin
                if (!debug_en) begin
                    state_nxt = ST_RUN;
                end else if (step_go) begin
                    state_nxt = ST_STEP;
                end
            end
            ST_STEP: begin
                state_nxt = ST_HALT;
            end
            ST_BREAK: begin
                if (debug_en) begin
                    state_nxt = ST_HALT;
                end else if (!bp_en) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    always_comb begin
        cpu_en = 1'b0;
        halted = 1'b0;
        bp_hit = 1'b0;
        unique case (state)
            ST_RUN:   cpu_en = active;
            ST_STEP:  cpu_en = active;
            ST_HALT:  halted = 1'b1;
            ST_BREAK: begin
                halted = 1'b1;
                bp_hit = 1'b1;
            end
            default: begin
                cpu_en = 1'b0;
            end
        endcase
    end

    // Interrupts raised while the CPU is stopped are held until it next advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_pending <= 1'b0;
        end else if (cpu_en) begin
            irq_pending <= 1'b0;
        end else if (interrupter) begin
            irq_pending <= 1'b1;
        end
    end

    assign irq_out = cpu_en & (interrupter | irq_pending);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt <= '0;
        end else if (cpu_en) begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
        end
    end

endmodule
